// File: rtl/seq_divider_pkg.sv
// Shared types and constants for the sequential restoring divider (package div_pkg).
package div_pkg;

    localparam int DIV_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_e;

    // Fill bit of the divide-by-zero quotient; replicated to the operand width
    // by the user so the helper stays width-agnostic.
    function automatic logic dbz_fill_bit();
        return 1'b1;
    endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Operand and result handshakes of the divider, bundled for port connection.
interface seq_divider_if
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    // Producer of operands / consumer of results.
    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );

    // The divider itself.
    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider_div_step.sv
// One combinational radix-2 restoring step: shift in the next dividend bit,
// trial-subtract the divisor, keep the difference only if it did not go negative.
module div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             qbit_o
);
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // The shifted remainder is below 2*divisor, so the difference always fits in
    // WIDTH+1 bits and its top bit is the sign.
    always_comb begin
        shifted = {rem_i, bit_i};
        diff    = shifted - {1'b0, divisor_i};
        qbit_o  = ~diff[WIDTH];
        rem_o   = qbit_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    end
endmodule

// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divider, one quotient bit per cycle.
// Optional macro SIGNED_DIV_EN: two's complement operands, truncating division.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    seq_divider_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    state_e           state_q, state_d;
    // A restored partial remainder is always below the divisor, so the extra
    // top bit of the WIDTH+1-bit remainder is never set and is not stored.
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH-1:0] step_r, q_next;
    logic             step_q;

`ifdef SIGNED_DIV_EN
    logic qneg_q, qneg_d;
    logic rneg_q, rneg_d;

    // Magnitudes feed the unsigned loop; the most-negative value maps to itself,
    // which read as unsigned is exactly its magnitude.
    assign a_mag = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
    assign b_mag = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
`else
    assign a_mag = bus.dividend;
    assign b_mag = bus.divisor;
`endif

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (r_q),
        .bit_i     (q_q[WIDTH-1]),
        .divisor_i (dvsr_q),
        .rem_o     (step_r),
        .qbit_o    (step_q)
    );

    assign q_next = {q_q[WIDTH-2:0], step_q};

    assign bus.in_ready    = (state_q == IDLE);
    assign bus.out_valid   = (state_q == DONE);
    assign bus.quotient    = quot_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;

    // Next-state and datapath control.
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        dvsr_d  = dvsr_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        cnt_d   = cnt_q;
`ifdef SIGNED_DIV_EN
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    dvsr_d = b_mag;
                    dbz_d  = 1'b0;
`ifdef SIGNED_DIV_EN
                    qneg_d = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                    rneg_d = bus.dividend[WIDTH-1];
`endif
                    if (bus.divisor == '0) begin
                        quot_d  = {WIDTH{dbz_fill_bit()}};
                        rem_d   = bus.dividend;
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        r_d     = '0;
                        q_d     = a_mag;
                        cnt_d   = CW'(WIDTH - 1);
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                r_d   = step_r;
                q_d   = q_next;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
`ifdef SIGNED_DIV_EN
                    quot_d = qneg_q ? -q_next : q_next;
                    rem_d  = rneg_q ? -step_r : step_r;
`else
                    quot_d = q_next;
                    rem_d  = step_r;
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any division in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            r_q     <= '0;
            q_q     <= '0;
            dvsr_q  <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            cnt_q   <= '0;
`ifdef SIGNED_DIV_EN
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            dvsr_q  <= dvsr_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            cnt_q   <= cnt_d;
`ifdef SIGNED_DIV_EN
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
`endif
        end
    end
endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: driver pushes model results, monitor pops
// and compares whenever a result is presented.
module tb_seq_divider;
    localparam int W = 8;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           lat;
        int           acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   seen = 1'b0;
    bit   rand_rdy = 1'b0;
    exp_t expq[$];
    exp_t cur;

    seq_divider_if #(.WIDTH(W)) bus ();

    seq_divider #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void chk(string nm, int unsigned got, int unsigned exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, exp, cyc);
        end
    endfunction

    // Reference: plain arithmetic on the operand values.
    function automatic exp_t model(logic [W-1:0] a, logic [W-1:0] b);
        exp_t e;
        e.acc = 0;
        if (b == 0) begin
            e.q = '1; e.r = a; e.dbz = 1'b1; e.lat = 1;
        end else begin
            e.dbz = 1'b0; e.lat = W + 1;
`ifdef SIGNED_DIV_EN
            begin
                int sa, sb;
                sa = $signed(a);
                sb = $signed(b);
                if (sa == -(1 << (W - 1)) && sb == -1) begin
                    e.q = a; e.r = '0;
                end else begin
                    e.q = W'(sa / sb);
                    e.r = W'(sa % sb);
                end
            end
`else
            e.q = a / b;
            e.r = a % b;
`endif
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        int n = 0;
        exp_t e;
        while (!bus.in_ready && n < 300) begin
            tick();
            n++;
        end
        if (!bus.in_ready) begin
            checks++; errors++;
            $display("FAIL issue_timeout: in_ready stuck at 0, wanted 1");
            return;
        end
        bus.in_valid = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        tick();
        bus.in_valid = 1'b0;
        e = model(a, b);
        e.acc = cyc;
        expq.push_back(e);
        chk("in_ready_after_accept", bus.in_ready, 0);
    endtask

    task automatic drain();
        int n = 0;
        while ((expq.size() != 0 || seen) && n < 300) begin
            tick();
            n++;
        end
        if (expq.size() != 0 || seen) begin
            checks++; errors++;
            $display("FAIL drain_timeout: %0d results outstanding, wanted 0", expq.size());
        end
    endtask

    // Monitor: compare each presented result once, then check it holds.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            seen = 1'b0;
        end else if (bus.out_valid) begin
            if (!seen) begin
                if (expq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_result: got q=%0d r=%0d, wanted no result",
                             bus.quotient, bus.remainder);
                end else begin
                    cur  = expq.pop_front();
                    seen = 1'b1;
                    chk("quotient", bus.quotient, cur.q);
                    chk("remainder", bus.remainder, cur.r);
                    chk("div_by_zero", bus.div_by_zero, cur.dbz);
                    chk("latency", cyc - cur.acc + 1, cur.lat);
                end
            end else begin
                chk("hold_quotient", bus.quotient, cur.q);
                chk("hold_remainder", bus.remainder, cur.r);
                chk("hold_div_by_zero", bus.div_by_zero, cur.dbz);
            end
            if (bus.out_ready) seen = 1'b0;
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rand_rdy) bus.out_ready = ($urandom_range(0, 1) == 1);
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        bus.out_ready = 1'b1;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_quotient", bus.quotient, 0);
        chk("rst_remainder", bus.remainder, 0);
        chk("rst_div_by_zero", bus.div_by_zero, 0);

        // Directed unsigned-valued cases
        issue(8'd100, 8'd7);
        drain();
        issue(8'd255, 8'd1);
        issue(8'd0,   8'd5);
        issue(8'd3,   8'd200);
        drain();
        issue(8'd5,   8'd0);
        issue(8'd9,   8'd3);
        drain();

        // Back-pressure: result held, stray in_valid pulses ignored
        bus.out_ready = 1'b0;
        issue(8'd200, 8'd9);
        begin
            int n = 0;
            while (!bus.out_valid && n < 50) begin tick(); n++; end
        end
        chk("bp_out_valid", bus.out_valid, 1);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = i[0];
            bus.dividend = 8'd1;
            bus.divisor  = 8'd1;
            tick();
            chk("bp_in_ready", bus.in_ready, 0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drain();
        tick(); tick();

        // Reset in the middle of a calculation
        issue(8'd77, 8'd3);
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        expq.delete();
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_in_ready", bus.in_ready, 1);
        issue(8'd77, 8'd3);
        drain();

`ifdef SIGNED_DIV_EN
        issue(8'hF9, 8'h02);
        issue(8'h07, 8'hFE);
        issue(8'h80, 8'hFF);
        issue(8'hF9, 8'h00);
        drain();
`endif

        // Random sweep with random back-pressure
        rand_rdy = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            logic [W-1:0] a, b;
            a = W'($urandom);
            b = ($urandom_range(0, 15) == 0) ? '0 : W'($urandom);
            issue(a, b);
        end
        drain();
        rand_rdy = 1'b0;
        bus.out_ready = 1'b1;
        tick(); tick();
        chk("final_queue_empty", expq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
Iterative radix-2 restoring divider. It is the inverse-direction companion to the team's compressor-tree multiplier.
- Accepts a WIDTH-bit dividend and divisor over a valid/ready handshake.
- Produces one quotient bit per cycle.
- Returns quotient and remainder over a second valid/ready handshake.
- Sits beside the multiplier in the arithmetic datapath and lets the bench cross-check a*b/b == a.

Parameters:
WIDTH, 8, operand / quotient / remainder width in bits (>= 2)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  operands present
in_ready  output  1  block can accept operands (high only in IDLE)
dividend  input  WIDTH  numerator
divisor  input  WIDTH  denominator
out_valid  output  1  result present
out_ready  input  1  consumer accepts result
quotient  output  WIDTH  result quotient
remainder  output  WIDTH  result remainder
div_by_zero  output  1  divisor was zero for the current result

Behaviour:
- Reset (sampled on clk while rst=1): state=IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, div_by_zero=0, iteration counter=0. Reset overrides everything, including a calculation in progress; the partial result is discarded.
- States: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, latch dividend and divisor.
  - If divisor!=0: clear partial remainder R (WIDTH+1 bits), set Q=dividend, set count=WIDTH-1, go to CALC.
  - If divisor==0: go straight to DONE with quotient=all ones, remainder=dividend, div_by_zero=1.
- CALC (exactly WIDTH cycles), each cycle:
  - T = {R[WIDTH-1:0], Q[WIDTH-1]} - {1'b0, divisor}.
  - If T is non-negative: R=T, shift 1 into Q. Otherwise: R={R[WIDTH-1:0], Q[WIDTH-1]}, shift 0 into Q.
  - count decrements; when count==0 the step still executes, then go to DONE.
- DONE:
  - out_valid=1; quotient, remainder and div_by_zero are stable and must not change while out_valid=1 and out_ready=0.
  - On out_ready, go to IDLE and drop out_valid the next cycle.
- Latency, accept edge to out_valid high:
  - nonzero divisor: WIDTH+1 cycles (9 for WIDTH=8);
  - zero divisor: 1 cycle.
- Throughput: one division per WIDTH+2 cycles with out_ready held high.
- in_ready=0 in CALC and DONE; in_valid is ignored there.
- A new operand cannot be accepted in the same cycle a result is consumed. IDLE is always visited for at least one cycle.
- div_by_zero clears when the next operand is accepted.
- Unsigned invariant (divisor!=0): dividend == quotient*divisor + remainder, with remainder < divisor.

Optional Feature:
SIGNED_DIV_EN
- Defined:
  - Operands are two's complement.
  - Magnitudes are divided using the same CALC loop.
  - Quotient is negated when the operand signs differ (truncation toward zero).
  - Remainder takes the sign of the dividend.
  - Overflow case, most-negative / -1: quotient=most-negative, remainder=0, div_by_zero=0.
  - Divide by zero: quotient=-1 (all ones), remainder=dividend.
  - Sign fix-up is applied on the CALC->DONE transition, so latency is unchanged.
- Undefined: everything is unsigned and no sign logic is synthesized.

Decomposition:
- Package div_pkg holds:
  - state enum {IDLE, CALC, DONE};
  - default width constant DIV_WIDTH=8;
  - helper function for the all-ones divide-by-zero quotient.
- One sub-module, div_step: combinational single restoring step. Inputs are partial remainder, next dividend bit and divisor; outputs are the new partial remainder and the quotient bit. It is instantiated once inside seq_divider.

Test Plan:
- 100 / 7, out_ready=1 -> after 9 cycles: quotient=14, remainder=2, div_by_zero=0; out_valid high for 1 cycle.
- 255 / 1, then 0 / 5, then 3 / 200 -> results (255,0), (0,0), (0,3); in_ready low during each CALC; the results do not interfere with each other.
- 5 / 0 -> out_valid 1 cycle after accept: quotient=255, remainder=5, div_by_zero=1; the next division 9 / 3 gives (3,0) with div_by_zero=0.
- Back-pressure: 200 / 9 with out_ready=0 for 5 cycles -> quotient=22 and remainder=2 held stable, in_ready stays 0, in_valid pulses are ignored; one result is delivered when out_ready rises.
- Reset mid-op: assert rst 4 cycles into CALC of 77 / 3 -> the next cycle shows out_valid=0 and in_ready=1; a fresh 77 / 3 then yields (25,2).
- SIGNED_DIV_EN:
  - -7 / 2 -> (-3, -1);
  - 7 / -2 -> (-3, 1);
  - -128 / -1 -> (-128, 0);
  - a random unsigned sweep of 1000 pairs with the macro undefined matches the behavioural / and %.
